lm96570_spi_responder: RTL and testbench

- Register-file SPI responder that models the LM96570 beamformer's serial port inside the FPGA, at the far end of the LM96570 SPI master.
- Used for SPI loopback bring-up: checks master frames, timing and readback without the beamformer board fitted.
- Oversamples the SPI bus in the CLK domain, decodes read/write frames into an internal register array, and drives SPI_SDO on reads.
- Exposes a local readback port and status strobes to fabric logic and ISSP probes.

---
 rtl/lm96570_spi_responder.sv | 191 +++++++++++++++++++
 tb/tb_lm96570_spi_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm96570_spi_responder.sv
// LM96570 serial-port stand-in: oversamples the SPI bus on CLK, decodes
// read/write frames into a local register file and answers reads on SPI_SDO.
module lm96570_spi_responder #(
  parameter int REG_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_REGS    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  SPI_CS_N,
  input  logic                  SPI_SCK,
  input  logic                  SPI_SDI,
  output logic                  SPI_SDO,
  input  logic [ADDR_WIDTH-1:0] REG_RD_ADDR,
  output logic [REG_WIDTH-1:0]  REG_RD_DATA,
  output logic                  WR_STROBE,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic                  FRAME_ERR,
  output logic [15:0]           FRAME_CNT
);

  localparam int CNT_W = $clog2(REG_WIDTH + 2);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(REG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REG_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, END} state_t;

  // Stops one past a legal length so an over-long frame can never wrap back.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  // Stage p0: input synchronizers
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic                   cs_p0, sck_p0, sdi_p0;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
    end else begin
      cs_sync  <= (cs_sync << 1)  | SYNC_STAGES'(SPI_CS_N);
      sck_sync <= (sck_sync << 1) | SYNC_STAGES'(SPI_SCK);
      sdi_sync <= (sdi_sync << 1) | SYNC_STAGES'(SPI_SDI);
    end
  end

  assign cs_p0  = cs_sync[SYNC_STAGES-1];
  assign sck_p0 = sck_sync[SYNC_STAGES-1];
  assign sdi_p0 = sdi_sync[SYNC_STAGES-1];

  // Stage p1: edge detection on the synchronized bus
  logic cs_p1, sck_p1;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cs_p1  <= 1'b0;
      sck_p1 <= 1'b0;
    end else begin
      cs_p1  <= cs_p0;
      sck_p1 <= sck_p0;
    end
  end

  assign cs_fall  = cs_p1 & ~cs_p0;
  assign cs_rise  = ~cs_p1 & cs_p0;
  assign sck_rise = sck_p0 & ~sck_p1 & ~cs_p0;
  assign sck_fall = ~sck_p0 & sck_p1 & ~cs_p0;

  // Stage p2: frame decoder and register file
  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [ADDR_WIDTH-1:0] hdr;
  logic [ADDR_WIDTH:0]   hdr_next;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wr_shift;
  logic [REG_WIDTH-1:0]  rd_shift;
  logic [REG_WIDTH-1:0]  regs [NUM_REGS];
  logic                  sdo;
  logic                  wr_strobe;
  logic                  frame_err;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           frame_cnt;
  logic [REG_WIDTH-1:0]  rd_data;

  assign hdr_next = {hdr, sdi_p0};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      hdr       <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      wr_shift  <= '0;
      rd_shift  <= '0;
      sdo       <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (cs_fall) begin
            bit_cnt <= '0;
            hdr     <= '0;
            state   <= HEADER;
          end
        end
        HEADER: begin
          sdo <= 1'b0;
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sck_rise) begin
            hdr <= hdr_next[ADDR_WIDTH-1:0];
            if (bit_cnt == HDR_LAST) begin
              rw       <= hdr_next[ADDR_WIDTH];
              addr     <= hdr_next[ADDR_WIDTH-1:0];
              rd_shift <= in_range(hdr_next[ADDR_WIDTH-1:0]) ?
                          regs[hdr_next[ADDR_WIDTH-1:0]] : '0;
              bit_cnt  <= '0;
              state    <= DATA;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (cs_rise) begin
            sdo   <= 1'b0;
            state <= END;
          end else begin
            if (sck_rise) begin
              bit_cnt <= sat_inc(bit_cnt);
              if (!rw) wr_shift <= {wr_shift[REG_WIDTH-2:0], sdi_p0};
            end
            // Launch on the fall so the master sees a stable bit at its rise.
            if (sck_fall && rw) begin
              sdo      <= rd_shift[REG_WIDTH-1];
              rd_shift <= {rd_shift[REG_WIDTH-2:0], 1'b0};
            end
          end
        end
        END: begin
          sdo   <= 1'b0;
          state <= IDLE;
          if (bit_cnt == DATA_BITS) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (!rw && in_range(addr)) begin
              regs[addr] <= wr_shift;
              wr_strobe  <= 1'b1;
              wr_addr    <= addr;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Local readback sees the pre-commit value in the commit cycle.
  always_ff @(posedge CLK) begin
    if (!RESET_N) rd_data <= '0;
    else          rd_data <= in_range(REG_RD_ADDR) ? regs[REG_RD_ADDR] : '0;
  end

  assign SPI_SDO     = sdo;
  assign REG_RD_DATA = rd_data;
  assign WR_STROBE   = wr_strobe;
  assign WR_ADDR     = wr_addr;
  assign FRAME_ERR   = frame_err;
  assign FRAME_CNT   = frame_cnt;

endmodule

// File: tb/tb_lm96570_spi_responder.sv
// Bench for lm96570_spi_responder: drives SPI frames at SCK=CLK/10 and checks
// the DUT against a register-array model of the frame rules.
`timescale 1ns/1ps
module tb_lm96570_spi_responder;

  localparam int HALF = 5;
  localparam int GAP  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [4:0]  rd_addr = 5'd0;
  logic [63:0] rd_data;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic        frame_err;
  logic [15:0] frame_cnt;

  lm96570_spi_responder dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .SPI_CS_N    (cs_n),
    .SPI_SCK     (sck),
    .SPI_SDI     (sdi),
    .SPI_SDO     (sdo),
    .REG_RD_ADDR (rd_addr),
    .REG_RD_DATA (rd_data),
    .WR_STROBE   (wr_strobe),
    .WR_ADDR     (wr_addr),
    .FRAME_ERR   (frame_err),
    .FRAME_CNT   (frame_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] mregs [0:31];
  logic [15:0] exp_cnt = 16'd0;
  bit          chk_en = 1'b0;
  bit          rd_rand = 1'b1;
  logic [4:0]  rd_fixed = 5'd0;
  bit          same_arm = 1'b0;
  logic [63:0] same_old = 64'd0;
  logic [63:0] same_new = 64'd0;
  int          n_strobe = 0;
  int          n_err = 0;

  logic [4:0]  a_prev = 5'd0;
  bit          r_prev = 1'b0;
  bit          same_next = 1'b0;
  int          cs_hi = 0;

  function automatic logic [63:0] model_rd(input logic [4:0] a);
    return (a < 5'd24) ? mregs[a] : 64'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    exp_cnt = 16'd0;
  endtask

  // Per-cycle compare process; also owns the random local readback address.
  initial begin
    forever begin
      @(negedge clk);
      if (!r_prev) begin
        chk("rst_sdo", 64'(sdo), 64'd0);
        chk("rst_wr_strobe", 64'(wr_strobe), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
      end else begin
        if (wr_strobe) n_strobe++;
        if (frame_err) n_err++;
        if (chk_en) chk("rd_data", rd_data, model_rd(a_prev));
        if (same_next) begin
          chk("same_cycle_new", rd_data, same_new);
          same_next = 1'b0;
        end else if (same_arm && wr_strobe) begin
          chk("same_cycle_old", rd_data, same_old);
          same_next = 1'b1;
        end
      end
      cs_hi = cs_n ? cs_hi + 1 : 0;
      if (cs_hi >= 6) chk("sdo_cs_high", 64'(sdo), 64'd0);
      r_prev  = rst_n;
      rd_addr = rd_rand ? 5'($urandom_range(0, 31)) : rd_fixed;
      a_prev  = rd_addr;
    end
  end

  task automatic send_frame(input bit rw, input logic [4:0] a, input logic [63:0] d,
                            input int nb, input int rst_at, output logic [63:0] rb);
    int          s0, e0;
    bit          did_rst, good, exp_wr, exp_err, hdr_sdo;
    logic [63:0] exp_rb;
    rb      = 64'd0;
    hdr_sdo = 1'b0;
    did_rst = 1'b0;
    s0      = n_strobe;
    e0      = n_err;
    exp_rb  = model_rd(a);
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        clear_model();
        did_rst = 1'b1;
      end
      if (i == 0)             sdi = rw;
      else if (i < 6)         sdi = a[5-i];
      else if (i < 70 && !rw) sdi = d[69-i];
      else                    sdi = 1'b0;
      wait_clk(HALF);
      if (i < 6)       hdr_sdo = hdr_sdo | sdo;
      else if (i < 70) rb = {rb[62:0], sdo};
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
    end
    wait_clk(HALF);
    chk_en = 1'b0;
    cs_n = 1'b1;
    wait_clk(GAP);

    good    = (nb == 70) && !did_rst;
    exp_err = (nb != 70) && !did_rst;
    exp_wr  = good && !rw && (a < 5'd24);
    chk("wr_strobe_pulses", 64'(n_strobe - s0), 64'(exp_wr));
    chk("frame_err_pulses", 64'(n_err - e0), 64'(exp_err));
    if (good) exp_cnt = exp_cnt + 16'd1;
    if (exp_wr) mregs[a] = d;
    chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    if (exp_wr) chk("wr_addr", 64'(wr_addr), 64'(a));
    if (rw && nb >= 70 && !did_rst) chk("sdo_read", rb, exp_rb);
    if (nb > 0 && !did_rst) chk("sdo_header", 64'(hdr_sdo), 64'd0);
    chk_en = 1'b1;
  endtask

  task automatic peek(input logic [4:0] a, input logic [63:0] exp, input string name);
    rd_rand  = 1'b0;
    rd_fixed = a;
    wait_clk(3);
    chk(name, rd_data, exp);
    rd_rand = 1'b1;
  endtask

  initial begin
    logic [63:0] rb;
    logic [63:0] v;
    int          lens [5];
    bit          rw;
    logic [4:0]  a;
    int          nb;
    lens = '{0, 4, 40, 69, 72};
    clear_model();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(8);
    chk_en = 1'b1;

    send_frame(1'b0, 5'd3, 64'h0123456789ABCDEF, 70, -1, rb);
    chk("lit_cnt_1", 64'(frame_cnt), 64'd1);
    chk("lit_wr_addr_3", 64'(wr_addr), 64'd3);
    peek(5'd3, 64'h0123456789ABCDEF, "lit_rd_3");

    send_frame(1'b1, 5'd3, 64'd0, 70, -1, rb);
    chk("lit_read_3", rb, 64'h0123456789ABCDEF);
    chk("lit_cnt_2", 64'(frame_cnt), 64'd2);

    send_frame(1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 46, -1, rb);
    peek(5'd3, 64'h0123456789ABCDEF, "lit_short_keeps_3");
    chk("lit_cnt_short", 64'(frame_cnt), 64'd2);

    send_frame(1'b0, 5'd30, 64'h5555_AAAA_1234_5678, 70, -1, rb);
    send_frame(1'b1, 5'd30, 64'd0, 70, -1, rb);
    chk("lit_read_30", rb, 64'd0);
    chk("lit_cnt_4", 64'(frame_cnt), 64'd4);

    send_frame(1'b0, 5'd0, 64'hDEAD_BEEF_CAFE_F00D, 70, 50, rb);
    chk("lit_cnt_after_rst", 64'(frame_cnt), 64'd0);
    peek(5'd0, 64'd0, "lit_rd_0_after_rst");
    send_frame(1'b0, 5'd0, 64'hA5A5_5A5A_0F0F_F0F0, 70, -1, rb);
    chk("lit_cnt_rewrite", 64'(frame_cnt), 64'd1);

    send_frame(1'b0, 5'd7, 64'h1111_2222_3333_4444, 71, -1, rb);
    send_frame(1'b0, 5'd7, 64'h8765_4321_0FED_CBA9, 70, -1, rb);
    send_frame(1'b1, 5'd7, 64'd0, 70, -1, rb);
    chk("lit_read_7", rb, 64'h8765_4321_0FED_CBA9);
    send_frame(1'b1, 5'd0, 64'd0, 70, -1, rb);
    chk("lit_read_0", rb, 64'hA5A5_5A5A_0F0F_F0F0);

    send_frame(1'b0, 5'd5, 64'h0000_0000_0000_00C3, 70, -1, rb);
    rd_rand  = 1'b0;
    rd_fixed = 5'd5;
    same_old = model_rd(5'd5);
    same_new = 64'hFEDC_BA98_7654_3210;
    same_arm = 1'b1;
    send_frame(1'b0, 5'd5, same_new, 70, -1, rb);
    same_arm = 1'b0;
    rd_rand  = 1'b1;

    for (int k = 0; k < 3; k++) begin
      sck = 1'b1;
      wait_clk(HALF);
      sck = 1'b0;
      wait_clk(HALF);
    end
    send_frame(1'b1, 5'd5, 64'd0, 70, -1, rb);
    chk("lit_read_5", rb, 64'hFEDC_BA98_7654_3210);

    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      v  = {$urandom, $urandom};
      nb = ($urandom_range(0, 9) < 7) ? 70 : lens[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 0; j < 2; j++) begin
          sck = 1'b1;
          wait_clk(HALF);
          sck = 1'b0;
          wait_clk(HALF);
        end
      end
      send_frame(rw, a, v, nb, -1, rb);
      if ($urandom_range(0, 1) == 1) wait_clk($urandom_range(1, 30));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "time limit");
  end

endmodule
